// File: rtl/uart_rx_if.sv
// ============================================================================
// Module      : uart_rx_if
// Description : Serial line, baud setting and valid/ready word handshake of uart_rx.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

interface uart_rx_if #(
    parameter int DATA_WDTH = 8
);
    logic                 RXi;
    logic [31:0]          BAUD_RATEi;
    logic                 RDYi;
    logic [DATA_WDTH-1:0] DATAo;
    logic                 VALIDo;
    logic                 BUSYo;
    logic                 FRAME_ERRo;
    logic                 OVERRUNo;

    // Receiver side
    modport master (
        input  RXi, BAUD_RATEi, RDYi,
        output DATAo, VALIDo, BUSYo, FRAME_ERRo, OVERRUNo
    );

    // Line driver / word consumer side
    modport slave (
        output RXi, BAUD_RATEi, RDYi,
        input  DATAo, VALIDo, BUSYo, FRAME_ERRo, OVERRUNo
    );
endinterface

`default_nettype wire

// File: rtl/uart_rx.sv
// ============================================================================
// Module      : uart_rx
// Description : UART receiver (1 start, DATA_WDTH data LSB first, 1 stop), mid-bit
//               sampling at a runtime baud rate, valid/ready output register.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module uart_rx #(
    parameter int FREQ_CLK  = 100000000,
    parameter int DATA_WDTH = 8
) (
    input  wire logic   CLKip,
    input  wire logic   rst,
    uart_rx_if.master   bus
);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_START   = 2'd1,
        ST_RECEIVE = 2'd2,
        ST_STOP    = 2'd3
    } state_t;

    localparam int                 c_BIT_W    = $clog2(DATA_WDTH);
    localparam logic [c_BIT_W-1:0] c_LAST_BIT = c_BIT_W'(DATA_WDTH - 1);
    localparam logic [31:0]        c_FREQ     = 32'(FREQ_CLK);

    logic                 r_sync1;
    logic                 r_rx_s;
    logic                 r_rx_d;
    logic [1:0]           r_warm;
    logic                 r_armed;

    state_t               r_state;
    state_t               w_state_nxt;

    logic [31:0]          r_n;
    logic [31:0]          r_cnt;
    logic [31:0]          w_n;
    logic                 w_n_ok;
    logic                 w_fall;
    logic                 w_start_hit;
    logic                 w_bit_hit;

    logic [c_BIT_W-1:0]   r_bit;
    logic [DATA_WDTH-1:0] r_shift;
    logic [DATA_WDTH-1:0] r_data;
    logic                 r_valid;
    logic                 r_frame_err;
    logic                 r_overrun;

    // Edge detection is only armed once the synchroniser holds a genuine
    // post-reset high sample, so a line held low across reset cannot fake a start.
    always_ff @(posedge CLKip) begin
        if (rst) begin
            r_sync1 <= 1'b1;
            r_rx_s  <= 1'b1;
            r_rx_d  <= 1'b1;
            r_warm  <= 2'b00;
            r_armed <= 1'b0;
        end else begin
            r_sync1 <= bus.RXi;
            r_rx_s  <= r_sync1;
            r_rx_d  <= r_rx_s;
            r_warm  <= {r_warm[0], 1'b1};
            if (r_warm[1] && r_rx_s) begin
                r_armed <= 1'b1;
            end
        end
    end

    always_comb begin
        w_n = 32'd0;
        if (bus.BAUD_RATEi != 32'd0) begin
            w_n = c_FREQ / bus.BAUD_RATEi;
        end
        w_n_ok = (w_n >= 32'd4);
    end

    assign w_fall      = r_armed & r_rx_d & ~r_rx_s;
    assign w_start_hit = (r_cnt == ((r_n >> 1) - 32'd1));
    assign w_bit_hit   = (r_cnt == (r_n - 32'd1));

    always_ff @(posedge CLKip) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_fall && w_n_ok) begin
                    w_state_nxt = ST_START;
                end
            end
            ST_START: begin
                if (w_start_hit) begin
                    w_state_nxt = r_rx_s ? ST_IDLE : ST_RECEIVE;
                end
            end
            ST_RECEIVE: begin
                if (w_bit_hit && (r_bit == c_LAST_BIT)) begin
                    w_state_nxt = ST_STOP;
                end
            end
            ST_STOP: begin
                if (w_bit_hit) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge CLKip) begin
        if (rst) begin
            r_n         <= 32'd0;
            r_cnt       <= 32'd0;
            r_bit       <= '0;
            r_shift     <= '0;
            r_data      <= '0;
            r_valid     <= 1'b0;
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_frame_err <= 1'b0;
            r_overrun   <= 1'b0;
            if (r_valid && bus.RDYi) begin
                r_valid <= 1'b0;
            end

            case (r_state)
                ST_IDLE: begin
                    if (w_fall && w_n_ok) begin
                        r_n   <= w_n;
                        r_cnt <= 32'd0;
                    end
                end
                ST_START: begin
                    r_bit <= '0;
                    r_cnt <= w_start_hit ? 32'd0 : r_cnt + 32'd1;
                end
                ST_RECEIVE: begin
                    if (w_bit_hit) begin
                        r_cnt   <= 32'd0;
                        r_shift <= {r_rx_s, r_shift[DATA_WDTH-1:1]};
                        r_bit   <= r_bit + 1'b1;
                    end else begin
                        r_cnt <= r_cnt + 32'd1;
                    end
                end
                ST_STOP: begin
                    r_cnt <= r_cnt + 32'd1;
                    if (w_bit_hit) begin
                        // A good stop overrides the handshake clear above: the
                        // register always ends up holding the newest word.
                        if (r_rx_s) begin
                            r_data    <= r_shift;
                            r_valid   <= 1'b1;
                            r_overrun <= r_valid & ~bus.RDYi;
                        end else begin
                            r_frame_err <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.DATAo      = r_data;
    assign bus.VALIDo     = r_valid;
    assign bus.BUSYo      = (r_state != ST_IDLE);
    assign bus.FRAME_ERRo = r_frame_err;
    assign bus.OVERRUNo   = r_overrun;

endmodule

`default_nettype wire
